hash_msg_feeder: RTL
====================

HASH_MSG_FEEDER -- requirements
Module: hash_msg_feeder

Interface
REQ-001 Parameter DEPTH, 16, message buffer capacity in bytes (2..255).
REQ-002 Parameter GAP, 1, idle cycles between consecutive M_valid pulses (>=1).
REQ-003 Parameter TIMEOUT, 1024, maximum cycles spent waiting for hash_ready after the last byte.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 wr_valid  input  1  host byte-write request.
REQ-007 wr_data  input  8  host message byte.
REQ-008 wr_ready  output  1  buffer can accept wr_data this cycle.
REQ-009 start  input  1  single-cycle pulse that begins hashing the buffered message.
REQ-010 busy  output  1  high from accepted start until done.
REQ-011 done  output  1  one-cycle pulse when the digest or a timeout is reported.
REQ-012 err  output  1  timeout flag, valid with done, held until the next accepted start.
REQ-013 digest_out  output  32  captured digest, held until the next capture.
REQ-014 core_rst_n  output  1  active-low reset driven to the hash core.
REQ-015 M  output  8  byte to the hash core.
REQ-016 M_valid  output  1  byte strobe to the hash core.
REQ-017 input_length  output  64  message length in bytes to the hash core.
REQ-018 hash_ready  input  1  hash core result valid.
REQ-019 digest  input  32  hash core result.

Function
REQ-020 The block SHALL have states IDLE, CRST, SEND, GAPW, WAITH and FIN.
REQ-021 wr_ready SHALL equal (state==IDLE) && (count<DEPTH) && !start, so start has priority over a same-cycle write.
REQ-022 A write with wr_valid && wr_ready SHALL store wr_data at index count and increment count.
REQ-023 In IDLE, start with count>0 SHALL latch input_length=count zero-extended to 64 bits, clear err, set busy, and enter CRST; start with count==0 SHALL be ignored.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 CRST SHALL drive core_rst_n low for exactly 2 cycles, then enter SEND with byte index 0.
REQ-026 SEND SHALL hold M_valid high for exactly 1 cycle with M=buffer[index], then enter GAPW.
REQ-027 GAPW SHALL hold M_valid low for GAP cycles, then return to SEND with index+1, or enter WAITH if the last byte was sent.
REQ-028 M SHALL hold its last value while M_valid is low.
REQ-029 hash_ready SHALL be sampled only in WAITH; in any other state it is ignored.
REQ-030 In WAITH, hash_ready high SHALL load digest_out<=digest and enter FIN.
REQ-031 In WAITH, TIMEOUT cycles without hash_ready SHALL set err=1, leave digest_out unchanged, and enter FIN.
REQ-032 FIN SHALL pulse done for 1 cycle, clear busy and count, and return to IDLE; the buffer contents need not be cleared.
REQ-033 Minimum latency from start to the last M_valid SHALL be 2 + count + (count-1)*GAP cycles.

Reset
REQ-034 On rst_n low, state SHALL become IDLE asynchronously.
REQ-035 On rst_n low: count=0, busy=0, done=0, err=0, digest_out=0, M=0, M_valid=0, input_length=0, core_rst_n=0.
REQ-036 core_rst_n SHALL be 1 after reset release, except in CRST.
REQ-037 Reset asserted mid-message SHALL abort the message with no done pulse.

Verification
REQ-038 Write "ABCD", then pulse start -> core_rst_n low 2 cycles, input_length=4, M_valid pulses carry 41,42,43,44 spaced 1+GAP cycles apart; on hash_ready with digest=32'hDEADBEEF, digest_out=DEADBEEF, done pulses once, and err=0.
REQ-039 Write "HELLO" after test 1 completes -> fresh core reset and input_length=5 with bytes 48,45,4C,4C,4F.
REQ-040 Write DEPTH+1 bytes -> wr_ready low after DEPTH bytes, extra byte dropped, and input_length=DEPTH on start.
REQ-041 start with an empty buffer, start during busy, and a same-cycle wr_valid+start -> start is ignored in the first two cases; in the third, the byte is not stored and input_length excludes it.
REQ-042 hash_ready never asserts -> done pulses TIMEOUT cycles after entering WAITH, err=1, and digest_out is unchanged.
REQ-043 rst_n pulsed low during SEND -> outputs take reset values immediately, and no done pulse occurs.

Source files
------------

// File: rtl/hash_msg_feeder.sv
// Buffers a host message and streams it byte by byte into a hash core, then
// captures the digest or reports a timeout.
module hash_msg_feeder #(
    parameter int DEPTH   = 16,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] digest_out,
    output logic        core_rst_n,
    output logic [7:0]  M,
    output logic        M_valid,
    output logic [63:0] input_length,
    input  logic        hash_ready,
    input  logic [31:0] digest
);

    localparam int            AW           = $clog2(DEPTH);
    localparam int            CW           = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [31:0]   CRST_LAST    = 32'd1;
    localparam logic [31:0]   GAP_LAST     = 32'(GAP - 1);
    localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CRST, SEND, GAPW, WAITH, FIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] len_q, len_d;
    logic [31:0]   timer_q, timer_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   digest_q, digest_d;
    logic          core_rst_n_q, core_rst_n_d;
    logic [7:0]    m_q, m_d;
    logic          m_valid_q, m_valid_d;

    logic [7:0]    buf_mem [DEPTH];
    logic          wr_en;
    logic          start_ok;

    // start wins over a same-cycle write so the latched length never misses a byte.
    assign wr_ready = (state_q == IDLE) && (count_q < DEPTH_C) && !start;
    assign wr_en    = wr_valid && wr_ready;
    assign start_ok = (state_q == IDLE) && start && (count_q != '0);

    always_comb begin
        // NOTE: every variable gets a default first, so no branch leaves one unassigned and infers a latch.
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        len_d    = len_q;
        timer_d  = timer_q;
        err_d    = err_q;
        digest_d = digest_q;
        m_d      = m_q;

        if (wr_en) begin
            count_d = count_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    len_d   = count_q;
                    err_d   = 1'b0;
                    timer_d = '0;
                    state_d = CRST;
                end
            end
            CRST: begin
                if (timer_q == CRST_LAST) begin
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = SEND;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            SEND: begin
                timer_d = '0;
                state_d = GAPW;
            end
            GAPW: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (idx_q == len_q - CW'(1)) begin
                        state_d = WAITH;
                    end else begin
                        idx_d   = idx_q + CW'(1);
                        state_d = SEND;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            WAITH: begin
                // A result arriving on the final allowed cycle still counts as success.
                if (hash_ready) begin
                    digest_d = digest;
                    state_d  = FIN;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            FIN: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Core-facing strobes are registered from the next state so they line up with it.
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FIN);
        m_valid_d    = (state_d == SEND);
        core_rst_n_d = (state_d != CRST);
        if (state_d == SEND) begin
            m_d = buf_mem[idx_d[AW-1:0]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            digest_q     <= '0;
            core_rst_n_q <= 1'b0;
            m_q          <= '0;
            m_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            timer_q      <= timer_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            digest_q     <= digest_d;
            core_rst_n_q <= core_rst_n_d;
            m_q          <= m_d;
            m_valid_q    <= m_valid_d;
        end
    end

    // NOTE: the buffer is left unreset; count bounds every read, so stale bytes are never sent.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[count_q[AW-1:0]] <= wr_data;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign digest_out   = digest_q;
    assign core_rst_n   = core_rst_n_q;
    assign M            = m_q;
    assign M_valid      = m_valid_q;
    assign input_length = 64'(len_q);

endmodule
